// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the survival timer.
package game_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HELD} state_e;
  localparam int DIG_W = 4;
  localparam logic [4*DIG_W-1:0] SAT_VAL = 16'h9999;
  function automatic int ticks_per_cs(input int clk_hz);
    return clk_hz / 100;
  endfunction
endpackage

// File: rtl/survival_timer_if.sv
// survival_timer_if: game-control/display bundle around the survival timer.
interface survival_timer_if;
  import game_pkg::*;
  logic start;
  logic crash;
  logic clear_best;
  logic [DIG_W-1:0] dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0;
  logic running;
  logic new_best;
  modport master (
    output start, crash, clear_best,
    input  dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0, running, new_best
  );
  modport slave (
    input  start, crash, clear_best,
    output dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0, running, new_best
  );
endinterface

// File: rtl/survival_timer_bcd_digit.sv
// bcd_digit: one 0-9 decade counter with synchronous clear and ripple carry.
module bcd_digit
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             carry_out,
  output logic [DIG_W-1:0] q
);
  logic [DIG_W-1:0] q_q, q_d;
  logic wrap;
  always_comb begin
    wrap = q_q == DIG_W'(9);
    q_d = clr ? '0 : !inc ? q_q : wrap ? '0 : q_q + 1'b1;
    carry_out = inc && wrap;
  end
  always_ff @(posedge clk)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/survival_timer.sv
// survival_timer: centisecond run timer with best-time latch for an 8-digit display.
module survival_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input logic clk,
  input logic rst,
  survival_timer_if.slave bus
);
  localparam int TICKS_PER_CS = ticks_per_cs(CLK_HZ);
  localparam int PW = $clog2(TICKS_PER_CS);
  state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4*DIG_W-1:0] best_q, best_d, cur;
  logic new_best_q, new_best_d;
  logic run, tick, start_go, crash_go, beat;
  logic [4:0] carry;
  logic [DIG_W-1:0] dig [4];
  logic unused_carry;
  always_comb begin
    run = state_q == RUN;
    tick = run && presc_q == PW'(TICKS_PER_CS - 1);
    start_go = bus.start && !run;
    crash_go = bus.crash && run;
    beat = crash_go && cur > best_q;
    presc_d = bus.start ? '0 : !run ? presc_q : tick ? '0 : presc_q + 1'b1;
    state_d = start_go ? RUN : crash_go ? HELD : state_q;
    best_d = bus.clear_best ? '0 : beat ? cur : best_q;
    new_best_d = beat && !bus.clear_best;
    // a crash on a tick edge freezes the pre-tick value
    carry[0] = tick && !crash_go && cur != SAT_VAL;
  end
  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .rst       (rst),
      .inc       (carry[i]),
      .clr       (start_go),
      .carry_out (carry[i+1]),
      .q         (dig[i])
    );
  end
  assign cur = {dig[3], dig[2], dig[1], dig[0]};
  assign unused_carry = carry[4];
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      best_q <= '0;
      new_best_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      best_q <= best_d;
      new_best_q <= new_best_d;
    end
  assign {bus.dig7, bus.dig6, bus.dig5, bus.dig4} = best_q;
  assign {bus.dig3, bus.dig2, bus.dig1, bus.dig0} = cur;
  assign bus.running = run;
  assign bus.new_best = new_best_q;
endmodule

// File: tb/tb_survival_timer.sv
// tb_survival_timer: directed table, saturation run and randomized model check.
module tb_survival_timer;
  localparam int TPC = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  survival_timer_if bus ();
  survival_timer_if sbus ();
  survival_timer #(.CLK_HZ(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
  survival_timer #(.CLK_HZ(200)) dut_s (.clk(clk), .rst(rst), .bus(sbus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int m_cur = 0, m_best = 0, m_p = 0, m_st = 0;
  bit m_nb = 0;
  typedef struct {
    logic st, cr, cb, rs;
    int idle;
    logic [15:0] cur, best;
    logic run, nb;
  } vec_t;
  vec_t tv [22];
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  task automatic model(input logic s, c, b, r);
    bit tick, sg, cg, win;
    if (r) begin
      m_cur = 0; m_best = 0; m_p = 0; m_st = 0; m_nb = 0;
      return;
    end
    tick = m_st == 1 && m_p == TPC - 1;
    sg = s && m_st != 1;
    cg = c && m_st == 1;
    win = cg && m_cur > m_best;
    m_nb = win && !b;
    m_best = b ? 0 : win ? m_cur : m_best;
    if (sg) m_cur = 0;
    else if (tick && !cg) m_cur = m_cur < 9999 ? m_cur + 1 : 9999;
    m_p = s ? 0 : m_st != 1 ? m_p : tick ? 0 : m_p + 1;
    m_st = sg ? 1 : cg ? 2 : m_st;
  endtask
  task automatic step(input logic s, c, b, r);
    bus.start = s; bus.crash = c; bus.clear_best = b; rst = r;
    @(posedge clk);
    model(s, c, b, r);
    @(negedge clk);
    bus.start = 0; bus.crash = 0; bus.clear_best = 0; rst = 0;
  endtask
  task automatic check_model(input string tag);
    logic [33:0] act, exp;
    act = {bus.dig7, bus.dig6, bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0,
           bus.running, bus.new_best};
    exp = {to_bcd(m_best), to_bcd(m_cur), m_st == 1, m_nb};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic check_sat(input string tag, input logic [15:0] cur);
    logic [33:0] act, exp;
    act = {sbus.dig7, sbus.dig6, sbus.dig5, sbus.dig4, sbus.dig3, sbus.dig2, sbus.dig1, sbus.dig0,
           sbus.running, sbus.new_best};
    exp = {16'h0000, cur, 1'b1, 1'b0};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  initial begin
    logic [33:0] act, exp;
    bus.start = 0; bus.crash = 0; bus.clear_best = 0;
    sbus.start = 0; sbus.crash = 0; sbus.clear_best = 0;
    tv[0]  = '{0, 0, 0, 1, 0,    16'h0000, 16'h0000, 0, 0};
    tv[1]  = '{1, 0, 0, 0, 0,    16'h0000, 16'h0000, 1, 0};
    tv[2]  = '{0, 0, 0, 0, 1229, 16'h0123, 16'h0000, 1, 0};
    tv[3]  = '{0, 0, 0, 0, 3769, 16'h0500, 16'h0000, 1, 0};
    tv[4]  = '{0, 1, 0, 0, 0,    16'h0500, 16'h0500, 0, 1};
    tv[5]  = '{0, 0, 0, 0, 0,    16'h0500, 16'h0500, 0, 0};
    tv[6]  = '{1, 0, 0, 0, 3000, 16'h0300, 16'h0500, 1, 0};
    tv[7]  = '{0, 1, 0, 0, 0,    16'h0300, 16'h0500, 0, 0};
    tv[8]  = '{0, 0, 1, 0, 0,    16'h0300, 16'h0000, 0, 0};
    tv[9]  = '{1, 0, 0, 0, 419,  16'h0041, 16'h0000, 1, 0};
    tv[10] = '{0, 1, 0, 0, 0,    16'h0041, 16'h0041, 0, 1};
    tv[11] = '{1, 0, 0, 0, 5,    16'h0000, 16'h0041, 1, 0};
    tv[12] = '{1, 1, 0, 0, 0,    16'h0000, 16'h0041, 0, 0};
    tv[13] = '{1, 1, 0, 0, 0,    16'h0000, 16'h0041, 1, 0};
    tv[14] = '{0, 0, 0, 0, 499,  16'h0050, 16'h0041, 1, 0};
    tv[15] = '{0, 1, 1, 0, 0,    16'h0050, 16'h0000, 0, 0};
    tv[16] = '{1, 0, 0, 0, 200,  16'h0020, 16'h0000, 1, 0};
    tv[17] = '{0, 1, 0, 0, 0,    16'h0020, 16'h0020, 0, 1};
    tv[18] = '{1, 0, 0, 0, 37,   16'h0003, 16'h0020, 1, 0};
    tv[19] = '{0, 0, 0, 1, 0,    16'h0000, 16'h0000, 0, 0};
    tv[20] = '{0, 1, 0, 0, 0,    16'h0000, 16'h0000, 0, 0};
    tv[21] = '{1, 0, 0, 0, 10,   16'h0001, 16'h0000, 1, 0};
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_model("reset");
    // two-cycle tick DUT reaches 99.99 in about 20k cycles
    sbus.start = 1;
    step(0, 0, 0, 0);
    sbus.start = 0;
    repeat (19996) step(0, 0, 0, 0);
    check_sat("sat_9998", 16'h9998);
    repeat (2) step(0, 0, 0, 0);
    check_sat("sat_9999", 16'h9999);
    repeat (100) step(0, 0, 0, 0);
    check_sat("sat_hold", 16'h9999);
    for (int i = 0; i < 22; i++) begin
      step(tv[i].st, tv[i].cr, tv[i].cb, tv[i].rs);
      repeat (tv[i].idle) step(0, 0, 0, 0);
      act = {bus.dig7, bus.dig6, bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0,
             bus.running, bus.new_best};
      exp = {tv[i].best, tv[i].cur, tv[i].run, tv[i].nb};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %h want %h", i, act, exp);
      end
      check_model($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(39) == 0, $urandom_range(59) == 0,
           $urandom_range(199) == 0, $urandom_range(1499) == 0);
      check_model($sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
